// File: rtl/jt900h_ramwr.sv
// Memory write controller: splits byte/word/long stores into 16-bit little-endian RAM beats.
// Optional one-entry posting buffer enabled by defining JT900H_RAMWR_POST_EN.
module jt900h_ramwr #(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          wr_en,
    output logic          wr_rdy,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [1:0]    wr_size,
    output logic          wr_busy,
    output logic          wr_done,
    output logic [AW-1:0] ram_waddr,
    output logic [15:0]   ram_din,
    output logic [1:0]    ram_we,
    input  logic          ram_ok
);

    typedef enum logic {IDLE, BEAT} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    we;
    } beat_t;

    state_t        state, state_nx;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic [1:0]    req_size;
    logic [1:0]    cnt;
    logic          ack, last_ack, accept, start_new, load_buf;
    logic [AW-1:0] src_addr;
    logic [31:0]   src_data;
    logic [1:0]    src_size;
    beat_t         first_beat, next_beat;

    function automatic logic [1:0] beat_count(input logic odd, input logic [1:0] size);
        case (size)
            2'd2:    beat_count = odd ? 2'd3 : 2'd2;
            2'd1:    beat_count = odd ? 2'd2 : 2'd1;
            default: beat_count = 2'd1;
        endcase
    endfunction

    // Beat idx of a store: lane contents follow from the start address parity
    function automatic beat_t beat_fn(input logic [AW-1:0] a, input logic [31:0] d,
                                      input logic [1:0] size, input logic [1:0] idx);
        beat_t b;
        b.addr = {a[AW-1:1], 1'b0} + {{(AW-3){1'b0}}, idx, 1'b0};
        b.din  = 16'h0000;
        b.we   = 2'b00;
        case (size)
            2'd2: begin
                if (!a[0]) begin
                    b.we  = 2'b11;
                    b.din = (idx == 2'd0) ? d[15:0] : d[31:16];
                end else begin
                    case (idx)
                        2'd0:    begin b.we = 2'b10; b.din = {d[7:0], 8'h00}; end
                        2'd1:    begin b.we = 2'b11; b.din = d[23:8]; end
                        default: begin b.we = 2'b01; b.din = {8'h00, d[31:24]}; end
                    endcase
                end
            end
            2'd1: begin
                if (!a[0]) begin
                    b.we  = 2'b11;
                    b.din = d[15:0];
                end else if (idx == 2'd0) begin
                    b.we  = 2'b10;
                    b.din = {d[7:0], 8'h00};
                end else begin
                    b.we  = 2'b01;
                    b.din = {8'h00, d[15:8]};
                end
            end
            default: begin
                b.we  = a[0] ? 2'b10 : 2'b01;
                b.din = a[0] ? {d[7:0], 8'h00} : {8'h00, d[7:0]};
            end
        endcase
        return b;
    endfunction

    assign ack      = cen && ram_ok && (state == BEAT);
    assign last_ack = ack && (cnt == beat_count(req_addr[0], req_size) - 2'd1);
    assign accept   = cen && wr_en && wr_rdy;
    assign wr_busy  = (state == BEAT);

`ifdef JT900H_RAMWR_POST_EN
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [31:0]   buf_data;
    logic [1:0]    buf_size;

    assign wr_rdy    = !buf_valid;
    assign start_new = accept && ((state == IDLE) || last_ack);
    assign load_buf  = last_ack && buf_valid;
    assign src_addr  = load_buf ? buf_addr : wr_addr;
    assign src_data  = load_buf ? buf_data : wr_data;
    assign src_size  = load_buf ? buf_size : wr_size;

    // A request arriving mid-store parks here until the current store's last ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_size  <= '0;
        end else if (cen) begin
            if (load_buf) begin
                buf_valid <= 1'b0;
            end else if (accept && !start_new) begin
                buf_valid <= 1'b1;
                buf_addr  <= wr_addr;
                buf_data  <= wr_data;
                buf_size  <= wr_size;
            end
        end
    end
`else
    assign wr_rdy    = (state == IDLE);
    assign start_new = accept;
    assign load_buf  = 1'b0;
    assign src_addr  = wr_addr;
    assign src_data  = wr_data;
    assign src_size  = wr_size;
`endif

    assign first_beat = beat_fn(src_addr, src_data, src_size, 2'd0);
    assign next_beat  = beat_fn(req_addr, req_data, req_size, cnt + 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (cen) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = BEAT;
            BEAT: if (last_ack && !(start_new || load_buf)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Beat outputs are registered; a new store overrides the idle return on its last ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr  <= '0;
            req_data  <= '0;
            req_size  <= '0;
            cnt       <= '0;
            ram_waddr <= '0;
            ram_din   <= '0;
            ram_we    <= '0;
            wr_done   <= 1'b0;
        end else if (cen) begin
            wr_done <= last_ack;
            if (start_new || load_buf) begin
                req_addr  <= src_addr;
                req_data  <= src_data;
                req_size  <= src_size;
                cnt       <= 2'd0;
                ram_waddr <= first_beat.addr;
                ram_din   <= first_beat.din;
                ram_we    <= first_beat.we;
            end else if (last_ack) begin
                ram_we <= 2'b00;
                cnt    <= 2'd0;
            end else if (ack) begin
                cnt       <= cnt + 2'd1;
                ram_waddr <= next_beat.addr;
                ram_din   <= next_beat.din;
                ram_we    <= next_beat.we;
            end
        end
    end

endmodule

// File: tb/tb_jt900h_ramwr.sv
// Scoreboard bench for jt900h_ramwr: expected beats come from a byte-level model of each store.
// Works with or without JT900H_RAMWR_POST_EN defined.
module tb_jt900h_ramwr;

    typedef struct {
        logic [23:0] addr;
        logic [15:0] din;
        logic [1:0]  we;
        bit          last;
    } beat_t;

    logic        clk, rst_n, cen, wr_en, wr_rdy, wr_busy, wr_done, ram_ok;
    logic [23:0] wr_addr, ram_waddr;
    logic [31:0] wr_data;
    logic [1:0]  wr_size, ram_we;
    logic [15:0] ram_din;

    beat_t exp_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    bit    rand_mode  = 0;
    bit    exp_done   = 0;

    jt900h_ramwr #(.AW(24)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .wr_en(wr_en), .wr_rdy(wr_rdy),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size),
        .wr_busy(wr_busy), .wr_done(wr_done), .ram_waddr(ram_waddr),
        .ram_din(ram_din), .ram_we(ram_we), .ram_ok(ram_ok)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every store byte k lands at address A+k; consecutive bytes sharing a 16-bit word form one beat
    task automatic pushStore(input logic [23:0] a, input logic [31:0] d, input logic [1:0] s);
        int          n;
        beat_t       b;
        bit          have;
        logic [23:0] ba;
        logic [31:0] dd;
        n    = (s == 2'd2) ? 4 : (s == 2'd1) ? 2 : 1;
        have = 0;
        b    = '{addr: 24'h0, din: 16'h0, we: 2'b00, last: 0};
        for (int k = 0; k < n; k++) begin
            ba = a + 24'(k);
            dd = d >> (8 * k);
            if (have && ({ba[23:1], 1'b0} != b.addr)) begin
                exp_q.push_back(b);
                have = 0;
            end
            if (!have) begin
                b    = '{addr: {ba[23:1], 1'b0}, din: 16'h0, we: 2'b00, last: 0};
                have = 1;
            end
            if (ba[0]) b.din[15:8] = dd[7:0];
            else       b.din[7:0]  = dd[7:0];
            b.we[ba[0]] = 1'b1;
        end
        b.last = 1;
        exp_q.push_back(b);
    endtask

    task automatic applyStimulus(input logic [23:0] a, input logic [31:0] d, input logic [1:0] s);
        int  budget;
        bit  taken;
        budget  = 0;
        taken   = 0;
        wr_addr = a;
        wr_data = d;
        wr_size = s;
        wr_en   = 1;
        while (!taken) begin
            @(negedge clk);
            if (cen && wr_rdy) taken = 1;
            else if (++budget > 2000) break;
        end
        if (!taken) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        if (taken) pushStore(a, d, s);
        #1;
        wr_en   = 0;
        wr_addr = 24'($urandom);
        wr_data = $urandom;
        wr_size = 2'($urandom);
    endtask

    task automatic waitIdle();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 || wr_busy) begin
            @(negedge clk);
            if (++budget > 3000) begin
                checkOutput("idle_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            cen    = ($urandom_range(0, 3) != 0);
            ram_ok = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: checks held beats every cycle and retires one on each acked edge
    always @(negedge clk) begin
        int  stores;
        bit  lastack;
        if (!rst_n) begin
            exp_done = 0;
        end else begin
            stores = 0;
            foreach (exp_q[i]) if (exp_q[i].last) stores++;
            checkOutput("done", 64'(wr_done), 64'(exp_done));
            checkOutput("busy", 64'(wr_busy), 64'(stores > 0));
`ifdef JT900H_RAMWR_POST_EN
            checkOutput("rdy", 64'(wr_rdy), 64'(stores <= 1));
`else
            checkOutput("rdy", 64'(wr_rdy), 64'(stores == 0));
`endif
            checkOutput("beat_active", 64'(ram_we != 2'b00), 64'(stores > 0));
            lastack = 0;
            if (ram_we != 2'b00 && exp_q.size() > 0) begin
                checkOutput("beat", {22'd0, ram_waddr, ram_din, ram_we},
                            {22'd0, exp_q[0].addr, exp_q[0].din, exp_q[0].we});
                if (cen && ram_ok) begin
                    lastack = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
            end
            if (cen) exp_done = lastack;
        end
    end

    initial begin
        logic [23:0] ra;
        rst_n = 0; cen = 0; ram_ok = 0; wr_en = 0;
        wr_addr = 0; wr_data = 0; wr_size = 0;
        #1;
        checkOutput("reset_we", 64'(ram_we), 64'd0);
        checkOutput("reset_addr", 64'(ram_waddr), 64'd0);
        checkOutput("reset_din", 64'(ram_din), 64'd0);
        checkOutput("reset_busy", 64'(wr_busy), 64'd0);
        checkOutput("reset_done", 64'(wr_done), 64'd0);
        checkOutput("reset_rdy", 64'(wr_rdy), 64'd1);
        #20;
        @(posedge clk); #1;
        rst_n = 1; cen = 1; ram_ok = 1;

        applyStimulus(24'h000101, 32'h0000005A, 2'd0);
        waitIdle();
        applyStimulus(24'h000201, 32'h11223344, 2'd2);
        waitIdle();

        // Held beat: ram_ok low for several cycles, one ram_ok pulse with cen low
        ram_ok = 0;
        applyStimulus(24'h000010, 32'h0000BEEF, 2'd1);
        repeat (2) begin @(posedge clk); #1; end
        cen = 0; ram_ok = 1;
        @(posedge clk); #1;
        cen = 1; ram_ok = 0;
        @(posedge clk); #1;
        ram_ok = 1;
        waitIdle();

        applyStimulus(24'hFFFFFE, 32'hCAFEBABE, 2'd2);
        waitIdle();

        // Reset during the second beat of an odd long store
        applyStimulus(24'h000201, 32'h11223344, 2'd2);
        @(posedge clk); #3;
        rst_n = 0;
        exp_q.delete();
        #1;
        checkOutput("abort_we", 64'(ram_we), 64'd0);
        checkOutput("abort_addr", 64'(ram_waddr), 64'd0);
        checkOutput("abort_din", 64'(ram_din), 64'd0);
        checkOutput("abort_rdy", 64'(wr_rdy), 64'd1);
        checkOutput("abort_busy", 64'(wr_busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (10) begin @(posedge clk); #1; end

        applyStimulus(24'h000400, 32'h00001234, 2'd1);
        applyStimulus(24'h000402, 32'h00005678, 2'd1);
        waitIdle();

        rand_mode = 1;
        for (int i = 0; i < 80; i++) begin
            ra = ($urandom_range(0, 4) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3)) : 24'($urandom);
            applyStimulus(ra, $urandom, 2'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            end
        end
        waitIdle();
        rand_mode = 0;
        repeat (3) begin @(posedge clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
